// File: rtl/ahbl_arb_pkg.sv
// Shared encodings for the two-master AHB-Lite arbiter: transfer types,
// owner identities and the starvation counter width.
package ahbl_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/ahbl_arb_next.sv
// Next address-phase owner decision for the two-master arbiter.
// Purely combinational; the caller registers the result.
module ahbl_arb_next
  import ahbl_arb_pkg::*;
#(
  parameter int RR           = 0,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                owner,
  input  logic                req0,
  input  logic                req1,
  input  logic                hready,
  input  logic                nonowner_stall,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                owner_nxt
);

  logic own_req;
  logic oth_req;
  logic starve_hit;

  always_comb begin
    own_req    = (owner == OWN1) ? req1 : req0;
    oth_req    = (owner == OWN1) ? req0 : req1;
    // Fires on the limit-th consecutive stalled cycle, so the loser waits
    // exactly STARVE_LIMIT cycles before it owns the address phase.
    starve_hit = (STARVE_LIMIT != 0) && nonowner_stall &&
                 (int'(starve_cnt) + 1 >= STARVE_LIMIT);
    owner_nxt  = owner;
    if (hready && oth_req) begin
      if (!own_req || (RR == 0 && owner == OWN1) || (RR != 0 && own_req) ||
          starve_hit) begin
        owner_nxt = ~owner;
      end
    end
  end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter (M0 = CPU, M1 = DMAC) onto one shared bus,
// with fixed-priority or round-robin ownership and a starvation limit.
module ahbl_master_arbiter
  import ahbl_arb_pkg::*;
#(
  parameter int RR           = 0,
  parameter int STARVE_LIMIT = 15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        GNT
);

  owner_e              addr_owner;
  owner_e              dp_owner;
  logic                dp_valid;
  logic [STARVE_W-1:0] starve_cnt;

  logic m0_req;
  logic m1_req;
  logic oth_req;
  logic oth_hready;
  logic nonowner_stall;
  logic owner_nxt;

  assign m0_req = M0_HTRANS[1];
  assign m1_req = M1_HTRANS[1];

  // Address phase: only the owner's request reaches the shared bus.
  always_comb begin
    HADDR  = (addr_owner == OWN1) ? M1_HADDR  : M0_HADDR;
    HTRANS = (addr_owner == OWN1) ? M1_HTRANS : M0_HTRANS;
    HWRITE = (addr_owner == OWN1) ? M1_HWRITE : M0_HWRITE;
    HSIZE  = (addr_owner == OWN1) ? M1_HSIZE  : M0_HSIZE;
    GNT    = addr_owner;
  end

  // Data phase: write data follows whoever owned the accepted address.
  always_comb begin
    HWDATA    = !dp_valid ? 32'h0 : ((dp_owner == OWN1) ? M1_HWDATA : M0_HWDATA);
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
    M0_HREADY = ((dp_valid && dp_owner == OWN0) || addr_owner == OWN0) ? HREADY : ~m0_req;
    M1_HREADY = ((dp_valid && dp_owner == OWN1) || addr_owner == OWN1) ? HREADY : ~m1_req;
  end

  always_comb begin
    oth_req        = (addr_owner == OWN1) ? m0_req : m1_req;
    oth_hready     = (addr_owner == OWN1) ? M0_HREADY : M1_HREADY;
    nonowner_stall = oth_req && !oth_hready;
  end

  ahbl_arb_next #(
    .RR           (RR),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_next (
    .owner          (addr_owner),
    .req0           (m0_req),
    .req1           (m1_req),
    .hready         (HREADY),
    .nonowner_stall (nonowner_stall),
    .starve_cnt     (starve_cnt),
    .owner_nxt      (owner_nxt)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_owner <= OWN0;
      dp_owner   <= OWN0;
      dp_valid   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      addr_owner <= owner_e'(owner_nxt);
      if (HREADY) begin
        dp_valid <= HTRANS[1];
        dp_owner <= addr_owner;
      end
      if (owner_nxt != addr_owner || !oth_req) begin
        starve_cnt <= '0;
      end else if (nonowner_stall && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Bench for ahbl_master_arbiter: vector table for cycle-exact behaviour plus
// starvation, round-robin, mixed-traffic scoreboard and mid-transfer reset sequences.
module tb_ahbl_master_arbiter;
  import ahbl_arb_pkg::*;

  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] ID = HTRANS_IDLE;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, hrdata_in;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, hready_in;
  logic [2:0]  m0_hsize, m1_hsize;

  logic        m0_hready, m1_hready, hwrite, gnt;
  logic [31:0] m0_hrdata, m1_hrdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        rr_m0_hready, rr_m1_hready, rr_hwrite, rr_gnt;
  logic [31:0] rr_m0_hrdata, rr_m1_hrdata, rr_haddr, rr_hwdata;
  logic [1:0]  rr_htrans;
  logic [2:0]  rr_hsize;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahbl_master_arbiter #(.RR(0), .STARVE_LIMIT(15)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
    .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready), .M0_HRDATA(m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
    .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready), .M1_HRDATA(m1_hrdata),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(hready_in), .HRDATA(hrdata_in), .GNT(gnt)
  );

  ahbl_master_arbiter #(.RR(1), .STARVE_LIMIT(15)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
    .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(rr_m0_hready), .M0_HRDATA(rr_m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
    .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(rr_m1_hready), .M1_HRDATA(rr_m1_hrdata),
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize), .HWDATA(rr_hwdata),
    .HREADY(hready_in), .HRDATA(hrdata_in), .GNT(rr_gnt)
  );

  typedef struct {
    logic rst; logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] d0;
    logic [1:0] t1; logic [31:0] a1; logic [31:0] d1; logic rdy; logic [31:0] rd;
    logic eg; logic [31:0] ea; logic [1:0] et; logic ew; logic [31:0] ed; logic e0; logic e1;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  function automatic vec_t mk(input logic rst, input logic [1:0] t0, input logic [31:0] a0,
                              input logic w0, input logic [31:0] d0, input logic [1:0] t1,
                              input logic [31:0] a1, input logic [31:0] d1, input logic rdy,
                              input logic [31:0] rd, input logic eg, input logic [31:0] ea,
                              input logic [1:0] et, input logic ew, input logic [31:0] ed,
                              input logic e0, input logic e1);
    vec_t r;
    r.rst = rst; r.t0 = t0; r.a0 = a0; r.w0 = w0; r.d0 = d0; r.t1 = t1; r.a1 = a1; r.d1 = d1;
    r.rdy = rdy; r.rd = rd; r.eg = eg; r.ea = ea; r.et = et; r.ew = ew; r.ed = ed;
    r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic rst, input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                     input logic [31:0] d0, input logic [1:0] t1, input logic [31:0] a1,
                     input logic w1, input logic [31:0] d1, input logic rdy, input logic [31:0] rd);
    HRESETn = rst; m0_htrans = t0; m0_haddr = a0; m0_hwrite = w0; m0_hwdata = d0;
    m1_htrans = t1; m1_haddr = a1; m1_hwrite = w1; m1_hwdata = d1;
    hready_in = rdy; hrdata_in = rd;
  endtask

  function automatic logic [31:0] wd(input logic [31:0] a);
    return {16'hD0D0, a[15:0]};
  endfunction

  function automatic logic [31:0] rdv(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic g[41];
    logic s[41];
    int st, late, i0, i1, n;
    int idx[2], done[2];
    logic dpv[2], dpw[2];
    logic [31:0] dpa[2];
    logic spv, spw, mr, acc;
    logic [31:0] spa, la;
    int seen[int unsigned];

    m0_hsize = 3'b010;
    m1_hsize = 3'b001;
    drv(0, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    repeat (2) @(posedge HCLK);

    // rst t0 a0 w0 d0 | t1 a1 d1 | rdy rdata || gnt haddr htrans hwrite hwdata m0rdy m1rdy
    vq.push_back(mk(0, NS, 32'h1000_0000, 0, 0, NS, 32'h2000_0000, 0, 1, 0,
                    0, 32'h1000_0000, NS, 0, 0, 1, 0));
    vq.push_back(mk(1, ID, 0, 0, 0, NS, 32'h2000_0010, 0, 1, 0,
                    0, 0, ID, 0, 0, 1, 0));
    vq.push_back(mk(1, ID, 0, 0, 0, NS, 32'h2000_0010, 0, 1, 0,
                    1, 32'h2000_0010, NS, 0, 0, 1, 1));
    vq.push_back(mk(1, ID, 0, 0, 0, ID, 0, 0, 1, 32'hA5A5_0001,
                    1, 0, ID, 0, 0, 1, 1));
    vq.push_back(mk(1, NS, 32'h3000_0000, 1, 32'hDEAD_0001, ID, 0, 0, 1, 0,
                    1, 0, ID, 0, 0, 0, 1));
    vq.push_back(mk(1, NS, 32'h3000_0000, 1, 32'hDEAD_0001, ID, 0, 0, 1, 0,
                    0, 32'h3000_0000, NS, 1, 0, 1, 1));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1, ID, 32'h3000_0000, 0, 32'hDEAD_0001, NS, 32'h2000_0020, 0, 0, 0,
                      0, 32'h3000_0000, ID, 0, 32'hDEAD_0001, 0, 0));
    vq.push_back(mk(1, ID, 32'h3000_0000, 0, 32'hDEAD_0001, NS, 32'h2000_0020, 0, 1, 0,
                    0, 32'h3000_0000, ID, 0, 32'hDEAD_0001, 1, 0));
    vq.push_back(mk(1, ID, 0, 0, 0, NS, 32'h2000_0020, 0, 1, 0,
                    1, 32'h2000_0020, NS, 0, 0, 1, 1));
    vq.push_back(mk(1, ID, 0, 0, 0, ID, 0, 32'h1111_1111, 1, 32'h5555_0002,
                    1, 0, ID, 0, 32'h1111_1111, 1, 1));
    vq.push_back(mk(1, NS, 32'h1000_0040, 0, 0, NS, 32'h2000_0040, 0, 1, 0,
                    1, 32'h2000_0040, NS, 0, 0, 0, 1));
    vq.push_back(mk(1, NS, 32'h1000_0040, 0, 0, ID, 0, 0, 1, 0,
                    0, 32'h1000_0040, NS, 0, 0, 1, 1));
    vq.push_back(mk(1, ID, 0, 0, 0, ID, 0, 0, 1, 32'h0BAD_0003,
                    0, 0, ID, 0, 0, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      cyc();
      drv(v.rst, v.t0, v.a0, v.w0, v.d0, v.t1, v.a1, 1'b0, v.d1, v.rdy, v.rd);
      @(negedge HCLK);
      chk($sformatf("v%0d.gnt", i), 32'(gnt), 32'(v.eg));
      chk($sformatf("v%0d.haddr", i), haddr, v.ea);
      chk($sformatf("v%0d.htrans", i), 32'(htrans), 32'(v.et));
      chk($sformatf("v%0d.hwrite", i), 32'(hwrite), 32'(v.ew));
      chk($sformatf("v%0d.hsize", i), 32'(hsize), v.eg ? 32'd1 : 32'd2);
      chk($sformatf("v%0d.hwdata", i), hwdata, v.ed);
      chk($sformatf("v%0d.m0_hready", i), 32'(m0_hready), 32'(v.e0));
      chk($sformatf("v%0d.m1_hready", i), 32'(m1_hready), 32'(v.e1));
      chk($sformatf("v%0d.m0_hrdata", i), m0_hrdata, v.rd);
      chk($sformatf("v%0d.m1_hrdata", i), m1_hrdata, v.rd);
    end

    // Fixed priority with both masters requesting: starvation limit grants M1 once.
    cyc();
    drv(0, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 40; c++) begin
      cyc();
      drv(1, NS, 32'h1000_0000 + 32'(c * 4), 0, 0, NS, 32'h2000_0000, 0, 0, 1, 0);
      @(negedge HCLK);
      g[c] = gnt;
      s[c] = m1_hready;
    end
    st = 0;
    for (int c = 1; c <= 40; c++) begin
      if (g[c] == 1'b0 && s[c] == 1'b0) st++;
      else break;
    end
    chk("starve.stalls", 32'(st), 32'd15);
    chk("starve.grant", 32'(g[16]), 32'd1);
    chk("starve.return", 32'(g[17]), 32'd0);
    late = 0;
    for (int c = 18; c <= 32; c++) if (g[c] == 1'b1) late++;
    chk("starve.regrant_early", 32'(late), 32'd0);
    chk("starve.regrant", 32'(g[33]), 32'd1);
    chk("starve.regrant_once", 32'(g[34]), 32'd0);

    // Round-robin, back-to-back requests from both masters.
    cyc();
    drv(0, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    i0 = 0;
    i1 = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      drv(1, NS, 32'h1000_0000 + 32'(i0 * 4), 0, 0, NS, 32'h2000_0000 + 32'(i1 * 4), 0, 0, 1, 0);
      @(negedge HCLK);
      chk($sformatf("rr.c%0d.gnt", c), 32'(rr_gnt), 32'((c - 1) % 2));
      chk($sformatf("rr.c%0d.haddr", c), rr_haddr,
          (((c - 1) % 2) == 1 ? 32'h2000_0000 : 32'h1000_0000) + 32'(((c - 1) / 2) * 4));
      if (c == 1) chk("rr.m1_first_stall", 32'(rr_m1_hready), 32'd0);
      else chk($sformatf("rr.c%0d.dp_done", c),
               32'((((c - 2) % 2) == 1) ? rr_m1_hready : rr_m0_hready), 32'd1);
      if (rr_gnt == 1'b0 && rr_m0_hready) i0++;
      if (rr_gnt == 1'b1 && rr_m1_hready) i1++;
    end

    // CPU reads on M0 against DMAC read/write traffic on M1, with wait states.
    cyc();
    drv(0, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    for (int m = 0; m < 2; m++) begin
      idx[m] = 0; done[m] = 0; dpv[m] = 0; dpw[m] = 0; dpa[m] = 0;
    end
    spv = 0; spw = 0; spa = 0;
    n = 0;
    while (!(idx[0] == 4 && idx[1] == 4 && !dpv[0] && !dpv[1] && !spv) && n < 300) begin
      cyc();
      HRESETn = 1;
      hready_in = (n % 5 != 3);
      m0_htrans = (idx[0] < 4) ? NS : ID;
      m0_haddr = 32'h1000_0100 + 32'(idx[0] * 4);
      m0_hwrite = 0;
      m0_hwdata = (dpv[0] && dpw[0]) ? wd(dpa[0]) : 32'h0;
      m1_htrans = (idx[1] < 4) ? NS : ID;
      m1_haddr = 32'h2000_0200 + 32'(idx[1] * 4);
      m1_hwrite = (idx[1] % 2 == 1);
      m1_hwdata = (dpv[1] && dpw[1]) ? wd(dpa[1]) : 32'h0;
      hrdata_in = (spv && !spw) ? rdv(spa) : 32'h0;
      @(negedge HCLK);
      if (hready_in) begin
        if (spv && spw) chk("mix.hwdata", hwdata, wd(spa));
        spv = 0;
        if (htrans[1]) begin
          chk("mix.owner", 32'(gnt), 32'(haddr[29]));
          chk("mix.dup", 32'(seen.exists(haddr)), 32'd0);
          seen[haddr] = 1;
          spv = 1; spa = haddr; spw = hwrite;
        end
      end
      for (int m = 0; m < 2; m++) begin
        mr = (m == 1) ? m1_hready : m0_hready;
        if (dpv[m] && mr) begin
          if (!dpw[m]) chk($sformatf("mix.m%0d_rdata", m), (m == 1) ? m1_hrdata : m0_hrdata, rdv(dpa[m]));
          done[m]++;
          dpv[m] = 0;
        end
        if (idx[m] < 4 && gnt == m[0] && mr) begin
          dpa[m] = (m == 1) ? 32'h2000_0200 + 32'(idx[m] * 4) : 32'h1000_0100 + 32'(idx[m] * 4);
          dpw[m] = (m == 1) && (idx[m] % 2 == 1);
          dpv[m] = 1;
          idx[m]++;
        end
      end
      n++;
    end
    chk("mix.timeout", 32'(n < 300), 32'd1);
    chk("mix.m0_done", 32'(done[0]), 32'd4);
    chk("mix.m1_done", 32'(done[1]), 32'd4);
    chk("mix.addr_count", 32'(seen.num()), 32'd8);

    // Reset during an M1 data phase abandons it.
    acc = 0;
    la = 32'h2000_0300;
    for (int c = 0; c < 6 && !acc; c++) begin
      cyc();
      drv(1, ID, 0, 0, 0, NS, la, 0, 0, 1, 0);
      @(negedge HCLK);
      if (gnt == 1'b1 && m1_hready) acc = 1;
    end
    chk("rst.m1_accept", 32'(acc), 32'd1);
    cyc();
    drv(0, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    @(negedge HCLK);
    chk("rst.dp_before", 32'(dut.dp_valid), 32'd1);
    cyc();
    drv(1, ID, 0, 0, 0, ID, 0, 0, 0, 1, 0);
    @(negedge HCLK);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.dp_valid", 32'(dut.dp_valid), 32'd0);
    chk("rst.m0_hready", 32'(m0_hready), 32'd1);
    chk("rst.m1_hready", 32'(m1_hready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
